gtrg_dav_fifo_n: RTL
====================

GTRG_DAV_FIFO_N -- requirements
Module: gtrg_dav_fifo_n

Interface
REQ-001 Parameter NCH, default 5: number of DAV channels (1..16).
REQ-002 Parameter AW, default 10: FIFO address width; depth is 2**AW entries.
REQ-003 Parameter SCOPEW, default 5: DAV scope window length in clocks (1..8).
REQ-004 Parameter AFULL_LVL, default 1000: almost-full threshold in entries.
REQ-005 CLK  in  1  clock; all logic is in this domain.
REQ-006 RST  in  1  reset, asynchronous, active-high.
REQ-007 BC0  in  1  bunch-crossing-zero; synchronous BX counter reset.
REQ-008 PUSH  in  1  L1A push request, one clock wide.
REQ-009 POP  in  1  read request for the next entry.
REQ-010 DAV  in  NCH  per-channel data-available pulses, asynchronous to CLK phase.
REQ-011 KILL  in  NCH  per-channel mask; 1 forces that channel's DAV to 0.
REQ-012 PUSHDLY  in  5  push and BX delay, 0..31 clocks.
REQ-013 DAVDLY  in  4  DAV delay, 0..15 clocks, shared by all channels.
REQ-014 DOUT  out  12+NCH  read data {bx[11:0], dav_or[NCH-1:0]}.
REQ-015 DVALID  out  1  DOUT holds a newly popped entry.
REQ-016 EMPTY, FULL, AFULL  out  1 each  FIFO status.
REQ-017 COUNT  out  AW+1  current occupancy.
REQ-018 OVFCNT  out  8  saturating count of dropped pushes.
REQ-019 ERR  out  1  sticky flag for overflow or underflow.
REQ-020 SCOPE  out  NCH*SCOPEW  DAV history captured at the last accepted push.

Function
REQ-021 DAV is synchronised by two flops, masked by KILL, then delayed by DAVDLY+1 clocks: dav_d.
REQ-022 A per-channel SCOPEW-deep shift register of dav_d is kept; dav_or[i] is the OR of dav_d[i] and its history.
REQ-023 The BX counter is 12 bits and increments every clock.
REQ-024 The BX counter loads 0 on BC0 or when it equals 3563; BC0 has priority.
REQ-025 PUSH and the BX count travel through the same delay line of PUSHDLY+1 clocks, giving dpush and dbx.
REQ-026 On dpush, if not FULL or if POP is accepted in the same cycle, write {dbx, dav_or} at the write pointer and increment it.
REQ-027 On dpush when FULL and POP is not accepted, drop the entry, increment OVFCNT (saturating at 255), and set ERR.
REQ-028 On POP when not EMPTY, read at the read pointer and increment it.
REQ-029 DOUT is registered; a popped entry appears on DOUT with DVALID=1 exactly one clock after POP.
REQ-030 DVALID is 0 in every other cycle, and DOUT holds its last value.
REQ-031 On POP when EMPTY (including the same cycle as a dpush into an empty FIFO), the pop is ignored and ERR is set.
REQ-032 COUNT changes as follows: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
REQ-033 Status flags: EMPTY=(COUNT==0), FULL=(COUNT==2**AW), AFULL=(COUNT>=AFULL_LVL); all are combinational from COUNT.
REQ-034 Pointers are AW bits and wrap from 2**AW-1 to 0.
REQ-035 SCOPE is loaded with every channel's {history, dav_d} on each accepted write.
REQ-036 PUSHDLY and DAVDLY may change at any time; entries already in the delay line are not guaranteed.

Reset
REQ-037 RST clears pointers, COUNT, OVFCNT, ERR, DVALID, DOUT, SCOPE, the BX counter, the synchroniser and scope registers, and the delay lines.
REQ-038 While RST is high: EMPTY=1, FULL=0, AFULL=0, and no write or read occurs.
REQ-039 RST asserted mid-operation discards all stored entries and pending delayed pushes; FIFO memory contents are not cleared.
REQ-040 ERR and OVFCNT are cleared only by RST.

Structure
REQ-041 Package gtrg_pkg holds the BX_MAX=3563 and BXW=12 constants and an entry-width function returning BXW+NCH.
REQ-042 Sub-module var_dly is a parametrised-width, 32-deep shift register with a selectable tap; it is used for the push/BX delay and the DAV delay.
REQ-043 FIFO storage is one inferred block RAM with a registered read.

Verification
REQ-044 PUSHDLY=3, DAVDLY=0, DAV[2] pulsed 2 clocks before PUSH, then POP -> one entry with dav_or=5'b00100; DVALID one clock after POP.
REQ-045 BC0 at t0, PUSH at t0+10, PUSHDLY=0 -> stored bx=10; with no BC0, the counter wraps 3563->0.
REQ-046 AW=4, 17 pushes without POP -> FULL after 16, OVFCNT=1, ERR=1, COUNT=16.
REQ-047 With FULL, dpush and POP in the same cycle -> COUNT stays 16, OVFCNT unchanged, data order preserved.
REQ-048 POP while EMPTY -> ERR=1, DVALID=0, COUNT=0; KILL[0]=1 with DAV[0] pulsed -> dav_or[0]=0.
REQ-049 RST asserted with COUNT=7 and a push in flight -> COUNT=0, EMPTY=1, and no late write after RST is released.

Source files
------------

// File: rtl/gtrg_pkg.sv
// Shared constants for the DAV/BX readout FIFO: bunch-crossing counter limits,
// delay-line depth and the FIFO entry width.
package gtrg_pkg;

    localparam int BXW = 12;
    localparam logic [BXW-1:0] BX_MAX = 12'd3563;
    localparam int DLY_DEPTH = 32;

    function automatic int entry_w(input int nch);
        return BXW + nch;
    endfunction

endpackage

// File: rtl/gtrg_dav_fifo_n_var_dly.sv
// 32-deep shift register with a selectable output tap.
// A tap of 0 gives one clock of delay.
module var_dly
    import gtrg_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [4:0]   tap_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] sr_q [DLY_DEPTH];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DLY_DEPTH; i++) sr_q[i] <= '0;
        end else begin
            sr_q[0] <= d_i;
            for (int i = 1; i < DLY_DEPTH; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    // The whole history is always kept, so moving the tap only changes which age is read.
    assign q_o = sr_q[tap_i];

endmodule

// File: rtl/gtrg_dav_fifo_n.sv
// L1A-triggered readout FIFO: stores the delayed BX count and a windowed OR of
// per-channel DAV pulses on each delayed push.
module gtrg_dav_fifo_n
    import gtrg_pkg::*;
#(
    parameter int NCH       = 5,
    parameter int AW        = 10,
    parameter int SCOPEW    = 5,
    parameter int AFULL_LVL = 1000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    BC0,
    input  logic                    PUSH,
    input  logic                    POP,
    input  logic [NCH-1:0]          DAV,
    input  logic [NCH-1:0]          KILL,
    input  logic [4:0]              PUSHDLY,
    input  logic [3:0]              DAVDLY,
    output logic [BXW+NCH-1:0]      DOUT,
    output logic                    DVALID,
    output logic                    EMPTY,
    output logic                    FULL,
    output logic                    AFULL,
    output logic [AW:0]             COUNT,
    output logic [7:0]              OVFCNT,
    output logic                    ERR,
    output logic [NCH*SCOPEW-1:0]   SCOPE
);

    localparam int EW = entry_w(NCH);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [NCH-1:0] sync1_q, sync2_q, dav_m, dav_d, dav_or;
    logic [NCH*SCOPEW-1:0] win_flat;
    logic [BXW-1:0] bx_q, bx_d, dbx;
    logic [BXW:0] pdly;
    logic dpush;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic [7:0] ovfcnt_q, ovfcnt_d;
    logic err_q, err_d;
    logic dvalid_q;
    logic [EW-1:0] dout_q;
    logic [NCH*SCOPEW-1:0] scope_q;
    logic [EW-1:0] mem_q [DEPTH];
    logic wr_en, rd_en;
    logic [EW-1:0] wr_data;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= DAV;
            sync2_q <= sync1_q;
        end
    end

    assign dav_m = sync2_q & ~KILL;

    var_dly #(.W(NCH)) u_dav_dly (
        .CLK   (CLK),
        .RST   (RST),
        .tap_i ({1'b0, DAVDLY}),
        .d_i   (dav_m),
        .q_o   (dav_d)
    );

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [SCOPEW-1:0] win;
        if (SCOPEW > 1) begin : g_hist
            logic [SCOPEW-2:0] hist_q;
            assign win = {hist_q, dav_d[c]};
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) hist_q <= '0;
                else     hist_q <= win[SCOPEW-2:0];
            end
        end else begin : g_nohist
            assign win = dav_d[c];
        end
        assign dav_or[c] = |win;
        assign win_flat[c*SCOPEW +: SCOPEW] = win;
    end

    // bx_d is the count belonging to the current cycle, so a BC0 cycle itself reads as 0.
    always_comb begin
        bx_d = bx_q + BXW'(1);
        if (bx_q == BX_MAX) bx_d = '0;
        if (BC0) bx_d = '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) bx_q <= '0;
        else     bx_q <= bx_d;
    end

    var_dly #(.W(BXW+1)) u_push_dly (
        .CLK   (CLK),
        .RST   (RST),
        .tap_i (PUSHDLY),
        .d_i   ({PUSH, bx_d}),
        .q_o   (pdly)
    );

    assign dpush   = pdly[BXW];
    assign dbx     = pdly[BXW-1:0];
    assign wr_data = {dbx, dav_or};

    assign EMPTY = (count_q == '0);
    assign FULL  = (count_q == DEPTH_C);
    assign AFULL = (32'(count_q) >= 32'(AFULL_LVL));

    always_comb begin
        rd_en    = POP && !EMPTY;
        wr_en    = dpush && (!FULL || rd_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovfcnt_d = ovfcnt_q;
        err_d    = err_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        if (dpush && !wr_en) begin
            err_d = 1'b1;
            if (ovfcnt_q != 8'hFF) ovfcnt_d = ovfcnt_q + 8'd1;
        end
        if (POP && !rd_en) err_d = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovfcnt_q <= '0;
            err_q    <= 1'b0;
            dvalid_q <= 1'b0;
            dout_q   <= '0;
            scope_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovfcnt_q <= ovfcnt_d;
            err_q    <= err_d;
            dvalid_q <= rd_en;
            if (rd_en) dout_q <= mem_q[rd_ptr_q];
            if (wr_en) scope_q <= win_flat;
        end
    end

    // When full with a simultaneous write, both pointers match; the read returns the old entry.
    always_ff @(posedge CLK) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    assign DOUT   = dout_q;
    assign DVALID = dvalid_q;
    assign COUNT  = count_q;
    assign OVFCNT = ovfcnt_q;
    assign ERR    = err_q;
    assign SCOPE  = scope_q;

endmodule
